ifetch_window: RTL and testbench

- Instruction prefetch buffer sitting directly upstream of the pipeline fetch stage.
- Fetches 8-byte aligned words from instruction memory over a req/ack handshake and keeps them in a small FIFO of consecutive words.
- Presents the 10-byte window starting at the fetch stage's PC (bytes pc..pc+9) as the 80-bit instruction bytes: icode/ifun in [7:0], rA/rB in [15:8], valC in [79:16] or [71:8].
- Handles sequential advance, redirects (mispredicted jump, ret) and memory address faults.

---
 rtl/ifetch_window.sv | 143 ++++++++++++++
 tb/tb_ifetch_window.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_window.sv
// Instruction prefetch buffer: fetches aligned 8-byte words into a small FIFO and
// presents the 10-byte window starting at the fetch-stage PC.
module ifetch_window #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fe_pc,
    output logic              fe_valid,
    output logic [79:0]       fe_bytes,
    output logic              fe_err,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [63:0]       imem_rdata,
    input  logic              imem_err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OffW = $clog2(8 * DEPTH);
    localparam int unsigned ErrW = 1 << (OffW - 3);
    localparam int unsigned XW   = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CntW-1:0]   count_q;
    logic [63:0]       data_q [DEPTH];
    logic [DEPTH-1:0]  err_q;

    // Compares are one bit wider than the address so that base+8*DEPTH never wraps.
    logic [XW-1:0] pc_x, base_x, end_x, lim_x, pc_end_x;
    assign pc_x     = {1'b0, fe_pc};
    assign base_x   = {1'b0, base_q};
    assign end_x    = base_x + (XW'(count_q) << 3);
    assign lim_x    = base_x + XW'(8 * DEPTH);
    assign pc_end_x = pc_x + XW'(10);

    logic redirect, drop;
    assign redirect = (pc_x < base_x) || (pc_x >= lim_x);
    assign drop     = (pc_x >= base_x + XW'(8)) && (pc_x < end_x);
    assign fe_valid = (pc_x >= base_x) && (pc_end_x <= end_x);

    logic [CntW-1:0]   cnt_drop;
    logic [ADDR_W-1:0] base_drop, req_addr, new_base;
    assign cnt_drop  = count_q - CntW'(drop);
    assign base_drop = drop ? base_q + ADDR_W'(8) : base_q;
    assign req_addr  = base_drop + (ADDR_W'(cnt_drop) << 3);
    assign new_base  = {fe_pc[ADDR_W-1:3], 3'b000};

    logic [7:0]      bytes_arr [8*DEPTH];
    logic [OffW-1:0] off;
    logic [ErrW-1:0] err_ext;
    assign off     = fe_pc[OffW-1:0] - base_q[OffW-1:0];
    assign err_ext = ErrW'(err_q);

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < 8; k++) begin
                bytes_arr[8*i+k] = data_q[i][8*k +: 8];
            end
        end
    end

    always_comb begin
        fe_bytes = '0;
        if (fe_valid) begin
            for (int k = 0; k < 10; k++) begin
                fe_bytes[8*k +: 8] = bytes_arr[off + OffW'(k)];
            end
        end
    end

    assign fe_err = fe_valid & err_ext[off[OffW-1:3]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            base_q    <= '0;
            count_q   <= '0;
            err_q     <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else if (redirect) begin
            base_q  <= new_base;
            count_q <= '0;
            err_q   <= '0;
            // An in-flight read must still complete; its data is thrown away.
            if (state_q != StIdle) begin
                if (imem_ack) begin
                    imem_req <= 1'b0;
                    state_q  <= StIdle;
                end else begin
                    state_q  <= StDiscard;
                end
            end
        end else begin
            if (drop) begin
                base_q  <= base_drop;
                count_q <= cnt_drop;
                err_q   <= err_q >> 1;
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    data_q[i] <= data_q[i+1];
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (cnt_drop < CntW'(DEPTH)) begin
                        imem_req  <= 1'b1;
                        imem_addr <= req_addr;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        for (int i = 0; i < int'(DEPTH); i++) begin
                            if (cnt_drop == CntW'(i)) begin
                                data_q[i] <= imem_rdata;
                                err_q[i]  <= imem_err;
                            end
                        end
                        count_q  <= cnt_drop + CntW'(1);
                        imem_req <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StDiscard: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_window.sv
// Bench for ifetch_window: directed scenarios plus random PC traffic, checked against a
// queue-based model of the buffered words and the outstanding request.
module tb_ifetch_window;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] fe_pc = '0;
    logic        fe_valid;
    logic [79:0] fe_bytes;
    logic        fe_err;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_rdata = '0;
    logic        imem_err = 1'b0;

    ifetch_window #(.DEPTH(DEPTH), .ADDR_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fe_pc      (fe_pc),
        .fe_valid   (fe_valid),
        .fe_bytes   (fe_bytes),
        .fe_err     (fe_err),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: buffered words as queues, plus one optional outstanding read.
    logic [63:0] m_base;
    logic [63:0] m_words [$];
    bit          m_errs [$];
    bit          m_pend;
    bit          m_disc;
    logic [63:0] m_addr;
    int          m_wait;
    int          lat;
    bit          rand_err;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        logic [63:0] b;
        for (int k = 0; k < 8; k++) begin
            b = a + 64'(k);
            w[8*k +: 8] = b[7:0] ^ b[23:16];
        end
        return w;
    endfunction

    function automatic bit mem_fault(input logic [63:0] a);
        return (a == 64'h108) || (rand_err && a[6:3] == 4'd5);
    endfunction

    function automatic bit model_valid(input logic [63:0] pc);
        logic [64:0] pcx, bx, ex;
        pcx = {1'b0, pc};
        bx  = {1'b0, m_base};
        ex  = bx + 65'(8 * m_words.size());
        return (pcx >= bx) && (pcx + 65'd10 <= ex);
    endfunction

    task automatic model_reset();
        m_base = '0;
        m_words.delete();
        m_errs.delete();
        m_pend = 1'b0;
        m_disc = 1'b0;
        m_addr = '0;
        m_wait = 0;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_all();
        bit          v;
        logic [79:0] eb;
        logic [63:0] w;
        bit          ee;
        int          off;
        int          o;
        v  = model_valid(fe_pc);
        eb = '0;
        ee = 1'b0;
        if (v) begin
            off = int'(fe_pc - m_base);
            for (int k = 0; k < 10; k++) begin
                o = off + k;
                w = m_words[o / 8];
                eb[8*k +: 8] = w[8*(o % 8) +: 8];
            end
            ee = m_errs[off / 8];
        end
        check("fe_valid", 80'(fe_valid), 80'(v));
        check("fe_bytes", fe_bytes, eb);
        check("fe_err", 80'(fe_err), 80'(ee));
        check("imem_req", 80'(imem_req), 80'(m_pend));
        if (m_pend) check("imem_addr", 80'(imem_addr), 80'(m_addr));
    endtask

    task automatic model_edge();
        logic [64:0] pcx, bx, ex;
        bit redir, adv, ackd, was_pend;
        pcx      = {1'b0, fe_pc};
        bx       = {1'b0, m_base};
        ex       = bx + 65'(8 * m_words.size());
        redir    = (pcx < bx) || (pcx >= bx + 65'(8 * DEPTH));
        adv      = (pcx >= bx + 65'd8) && (pcx < ex);
        ackd     = m_pend && imem_ack;
        was_pend = m_pend;
        if (redir) begin
            m_base = fe_pc & ~64'h7;
            m_words.delete();
            m_errs.delete();
            if (m_pend) begin
                if (ackd) begin
                    m_pend = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
        end else begin
            if (adv) begin
                void'(m_words.pop_front());
                void'(m_errs.pop_front());
                m_base = m_base + 64'd8;
            end
            if (m_pend) begin
                if (ackd) begin
                    if (!m_disc) begin
                        m_words.push_back(imem_rdata);
                        m_errs.push_back(imem_err);
                    end
                    m_pend = 1'b0;
                    m_disc = 1'b0;
                end
            end else if (m_words.size() < DEPTH) begin
                m_pend = 1'b1;
                m_addr = m_base + 64'(8 * m_words.size());
                m_wait = lat;
                was_pend = 1'b0;
            end
        end
        if (was_pend && m_pend && m_wait > 0) m_wait--;
    endtask

    // Called at a negedge: drive inputs, check, advance the model, wait for next negedge.
    task automatic step(input logic [63:0] pc);
        fe_pc      = pc;
        imem_ack   = m_pend && (m_wait == 0);
        imem_rdata = mem_word(m_addr);
        imem_err   = mem_fault(m_addr);
        #1;
        check_all();
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] pc;
        int          r;
        int          len;
        rand_err = 1'b0;
        lat = 0;
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 80'(fe_valid), 80'd0);
        check("rst_bytes", fe_bytes, 80'd0);
        check("rst_err", 80'(fe_err), 80'd0);
        check("rst_req", 80'(imem_req), 80'd0);
        check("rst_addr", 80'(imem_addr), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill from PC 0 with zero-wait memory
        repeat (10) step(64'h0);
        #1;
        check("t1_bytes", fe_bytes, 80'h09080706050403020100);
        check("t1_req_stopped", 80'(imem_req), 80'd0);
        check("t1_last_addr", 80'(imem_addr), 80'h18);

        // Sequential advance; the 0x28 refill gets a slow ack
        step(64'hA);
        step(64'h14);
        lat = 3;
        step(64'h1E);

        // Redirect while the read is outstanding
        lat = 0;
        repeat (14) step(64'h107);
        #1;
        check("t3_byte0", 80'(fe_bytes[7:0]), 80'h07);

        // Fault only on word 0x108
        step(64'h105);
        fe_pc = 64'h108;
        #1;
        check("t5_valid", 80'(fe_valid), 80'd1);
        check("t5_err", 80'(fe_err), 80'd1);
        lat = 2;
        step(64'h108);

        // Redirect landing on the same cycle as an ack
        for (int i = 0; i < 8 && !(m_pend && m_wait == 0); i++) step(64'h108);
        if (!(m_pend && m_wait == 0)) begin
            failures++;
            $error("FAIL t4_setup observed=no_ack_cycle expected=ack_cycle");
        end
        step(64'h40);
        lat = 0;
        repeat (8) step(64'h40);

        // Asynchronous reset while a read is outstanding
        lat = 5;
        step(64'h48);
        step(64'h48);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req", 80'(imem_req), 80'd0);
        check("t6_valid", 80'(fe_valid), 80'd0);
        check("t6_err", 80'(fe_err), 80'd0);
        check("t6_bytes", fe_bytes, 80'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        repeat (6) step(64'h0);

        // Random PC traffic with random read latency
        rand_err = 1'b1;
        pc = 64'h0;
        for (int n = 0; n < 500; n++) begin
            r   = int'($urandom_range(0, 15));
            lat = int'($urandom_range(0, 3));
            if (r == 0) begin
                pc = 64'($urandom_range(0, 1023));
            end else if (r == 1) begin
                pc = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
            end else if (r == 2) begin
                pc = pc - 64'd8;
            end else if (model_valid(pc)) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 2;
                    2: len = 9;
                    default: len = 10;
                endcase
                pc = pc + 64'(len);
            end
            step(pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
